// File: rtl/fake_data_checker.sv
// Checks a fake-telescope data stream against a constant, MFSR or counter predictor,
// tracking lock state and saturating error / word statistics.
module fake_data_checker #(
  parameter int                WIDTH = 24,
  parameter logic [WIDTH-1:0]  CDATA = '0,
  parameter int                LOCK  = 4,
  parameter int                LOSS  = 4,
  parameter int                CBITS = 16
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             count_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             locked_o,
  output logic             error_o,
  output logic [CBITS-1:0] errors_o,
  output logic [CBITS-1:0] words_o
);

  localparam int MW = $clog2(LOCK + 1);
  localparam int SW = $clog2(LOSS + 1);

  localparam logic [31:0]      SEED      = 32'h1;
  localparam logic [MW-1:0]    LOCK_N    = MW'(LOCK);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);
  localparam logic [SW-1:0]    LOSS_N    = SW'(LOSS);
  localparam logic [SW-1:0]    MISS_ONE  = SW'(1);
  localparam logic [CBITS-1:0] CNT_ONE   = CBITS'(1);
  localparam logic [WIDTH-1:0] WORD_ONE  = WIDTH'(1);

  localparam logic [1:0] MODE_CONST = 2'b00;
  localparam logic [1:0] MODE_MFSR  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [MW-1:0]     match_q, match_d;
  logic [SW-1:0]     miss_q, miss_d;
  logic [31:0]       r_q, r_d;
  logic [WIDTH-1:0]  e_q, e_d;
  logic [CBITS-1:0]  errors_q, errors_d;
  logic [CBITS-1:0]  words_q, words_d;
  logic              error_q, error_d;
  logic [1:0]        mode_q, mode_d;

  logic [1:0]        mode;
  logic [WIDTH-1:0]  exp_word;
  logic              hit;
  logic [MW-1:0]     match_inc;
  logic [SW-1:0]     miss_inc;
  logic [CBITS-1:0]  errors_inc;
  logic [CBITS-1:0]  words_inc;

  // Taps 32,22,2,1: a maximal-length sequence from any non-zero seed.
  function automatic logic [31:0] mfsr32(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  assign mode = {count_i, shift_i};

  always_comb begin
    exp_word = CDATA;
    if (mode == MODE_MFSR) begin
      exp_word = WIDTH'(r_q);
    end else if (mode == MODE_COUNT) begin
      exp_word = e_q;
    end
  end

  assign hit        = (data_i == exp_word);
  assign match_inc  = match_q + MATCH_ONE;
  assign miss_inc   = miss_q + MISS_ONE;
  assign errors_inc = (errors_q == '1) ? errors_q : errors_q + CNT_ONE;
  assign words_inc  = (words_q == '1) ? words_q : words_q + CNT_ONE;

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    miss_d   = miss_q;
    r_d      = r_q;
    e_d      = e_q;
    errors_d = errors_q;
    words_d  = words_q;
    error_d  = 1'b0;
    mode_d   = mode;

    if (!enable_i) begin
      state_d = IDLE;
      r_d     = SEED;
      match_d = '0;
      miss_d  = '0;
      if (clear_i) begin
        errors_d = '0;
        words_d  = '0;
      end
    end else if (clear_i) begin
      state_d  = ACQUIRE;
      errors_d = '0;
      words_d  = '0;
      match_d  = '0;
      miss_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = ACQUIRE;
    end else if (mode != mode_q) begin
      state_d = ACQUIRE;
      r_d     = SEED;
      match_d = '0;
      miss_d  = '0;
    end else if (valid_i && (mode != MODE_HOLD)) begin
      // Counter mode always re-seeds from the word; on a match this equals E + 1.
      if (mode == MODE_COUNT) begin
        e_d = data_i + WORD_ONE;
      end
      if (state_q == ACQUIRE) begin
        if (mode == MODE_COUNT) begin
          match_d = hit ? match_inc : MATCH_ONE;
        end else if (hit) begin
          match_d = match_inc;
          if (mode == MODE_MFSR) begin
            r_d = mfsr32(r_q);
          end
        end else begin
          match_d = '0;
          if (mode == MODE_MFSR) begin
            r_d = SEED;
          end
        end
        if (match_d == LOCK_N) begin
          state_d = LOCKED;
          miss_d  = '0;
        end
      end else begin
        words_d = words_inc;
        if (mode == MODE_MFSR) begin
          r_d = mfsr32(r_q);
        end
        if (hit) begin
          miss_d = '0;
        end else begin
          error_d  = 1'b1;
          errors_d = errors_inc;
          if (miss_inc == LOSS_N) begin
            state_d = ACQUIRE;
            match_d = '0;
            miss_d  = '0;
          end else begin
            miss_d = miss_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      match_q  <= '0;
      miss_q   <= '0;
      r_q      <= SEED;
      e_q      <= '0;
      errors_q <= '0;
      words_q  <= '0;
      error_q  <= 1'b0;
      mode_q   <= MODE_CONST;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      r_q      <= r_d;
      e_q      <= e_d;
      errors_q <= errors_d;
      words_q  <= words_d;
      error_q  <= error_d;
      mode_q   <= mode_d;
    end
  end

  assign locked_o = (state_q == LOCKED);
  assign error_o  = error_q;
  assign errors_o = errors_q;
  assign words_o  = words_q;

endmodule

// File: tb/tb_fake_data_checker.sv
// Self-checking bench: directed scenarios plus a randomized run against a behavioural model,
// using a default instance and a small-counter / long-loss instance driven in parallel.
module tb_fake_data_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0, clear = 1'b0, shift = 1'b0, count = 1'b0, valid = 1'b0;
  logic [23:0] data = '0;

  logic        locked_a, error_a, locked_b, error_b;
  logic [15:0] errors_a, words_a;
  logic [3:0]  errors_b, words_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fake_data_checker u_dut (
    .clock_i(clk), .reset_ni(reset_n), .enable_i(enable), .clear_i(clear),
    .shift_i(shift), .count_i(count), .valid_i(valid), .data_i(data),
    .locked_o(locked_a), .error_o(error_a), .errors_o(errors_a), .words_o(words_a)
  );

  fake_data_checker #(.WIDTH(24), .CDATA(24'h0), .LOCK(4), .LOSS(100), .CBITS(4)) u_sat (
    .clock_i(clk), .reset_ni(reset_n), .enable_i(enable), .clear_i(clear),
    .shift_i(shift), .count_i(count), .valid_i(valid), .data_i(data),
    .locked_o(locked_b), .error_o(error_b), .errors_o(errors_b), .words_o(words_b)
  );

  // Reference model: index 0 mirrors u_dut, index 1 mirrors u_sat.
  int        m_st[2];
  int        m_match[2];
  int        m_miss[2];
  bit [31:0] m_r[2];
  bit [23:0] m_e[2];
  int        m_errs[2];
  int        m_words[2];
  bit        m_err[2];
  int        m_mode[2];
  int        loss_v[2] = '{4, 100};
  int        cap_v[2]  = '{65535, 15};

  function automatic bit [31:0] mfsr_next(input bit [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  function automatic bit [23:0] model_expect(input int i, input int md);
    if (md == 1) return m_r[i][23:0];
    if (md == 2) return m_e[i];
    return 24'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_match[i] = 0; m_miss[i] = 0; m_r[i] = 32'h1; m_e[i] = '0;
      m_errs[i] = 0; m_words[i] = 0; m_err[i] = 0; m_mode[i] = 0;
    end
  endtask

  task automatic model_step();
    int md;
    bit hit;
    md = {count, shift};
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0;
      if (!reset_n) begin
        m_st[i] = 0; m_match[i] = 0; m_miss[i] = 0; m_r[i] = 32'h1; m_e[i] = '0;
        m_errs[i] = 0; m_words[i] = 0; m_mode[i] = 0;
        continue;
      end
      hit = (data == model_expect(i, md));
      if (!enable) begin
        m_st[i] = 0; m_r[i] = 32'h1; m_match[i] = 0; m_miss[i] = 0;
        if (clear) begin m_errs[i] = 0; m_words[i] = 0; end
      end else if (clear) begin
        m_st[i] = 1; m_errs[i] = 0; m_words[i] = 0; m_match[i] = 0; m_miss[i] = 0;
      end else if (m_st[i] == 0) begin
        m_st[i] = 1;
      end else if (md != m_mode[i]) begin
        m_st[i] = 1; m_r[i] = 32'h1; m_match[i] = 0; m_miss[i] = 0;
      end else if (valid && md != 3) begin
        if (md == 2) m_e[i] = data + 24'd1;
        if (m_st[i] == 1) begin
          if (hit) begin
            m_match[i]++;
            if (md == 1) m_r[i] = mfsr_next(m_r[i]);
          end else begin
            m_match[i] = (md == 2) ? 1 : 0;
            if (md == 1) m_r[i] = 32'h1;
          end
          if (m_match[i] == 4) begin m_st[i] = 2; m_miss[i] = 0; end
        end else begin
          if (m_words[i] < cap_v[i]) m_words[i]++;
          if (md == 1) m_r[i] = mfsr_next(m_r[i]);
          if (hit) m_miss[i] = 0;
          else begin
            m_err[i] = 1;
            if (m_errs[i] < cap_v[i]) m_errs[i]++;
            m_miss[i]++;
            if (m_miss[i] == loss_v[i]) begin m_st[i] = 1; m_match[i] = 0; m_miss[i] = 0; end
          end
        end
      end
      m_mode[i] = md;
    end
  endtask

  task automatic drive(input bit en, input bit clr, input bit [1:0] md, input bit vld, input bit [23:0] d);
    enable = en; clear = clr; {count, shift} = md; valid = vld; data = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    drive(0, 0, 2'b00, 0, 24'h0);
    drive(0, 0, 2'b00, 0, 24'h0);
    n_vec++; if ({locked_a, error_a} !== 2'b00) begin n_bad++; $display("FAIL reset_flags_a got %b want 00", {locked_a, error_a}); end
    n_vec++; if ({errors_a, words_a} !== 32'h0) begin n_bad++; $display("FAIL reset_counts_a got %h want 0", {errors_a, words_a}); end
    n_vec++; if ({locked_b, error_b, errors_b, words_b} !== 10'h0) begin n_bad++; $display("FAIL reset_b got %h want 0", {locked_b, error_b, errors_b, words_b}); end
    reset_n = 1'b1;
  endtask

  task automatic test_counter_lock();
    drive(1, 0, 2'b10, 0, 24'h0);
    drive(1, 0, 2'b10, 1, 24'd5);
    drive(1, 0, 2'b10, 1, 24'd6);
    drive(1, 0, 2'b10, 1, 24'd7);
    n_vec++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL cnt_early_lock got %b want 0", locked_a); end
    drive(1, 0, 2'b10, 1, 24'd8);
    n_vec++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL cnt_lock got %b want 1", locked_a); end
    drive(1, 0, 2'b10, 1, 24'd10);
    n_vec++; if (error_a !== 1'b1) begin n_bad++; $display("FAIL cnt_err_pulse got %b want 1", error_a); end
    n_vec++; if (errors_a !== 16'd1) begin n_bad++; $display("FAIL cnt_errors got %0d want 1", errors_a); end
    drive(1, 0, 2'b10, 1, 24'd11);
    n_vec++; if (error_a !== 1'b0) begin n_bad++; $display("FAIL cnt_reseed_match got %b want 0", error_a); end
    n_vec++; if (words_a !== 16'd2 || errors_a !== 16'd1) begin n_bad++; $display("FAIL cnt_counts got w=%0d e=%0d want w=2 e=1", words_a, errors_a); end
  endtask

  task automatic test_counter_wrap();
    drive(1, 1, 2'b10, 0, 24'h0);
    n_vec++; if ({locked_a, errors_a, words_a} !== 33'h0) begin n_bad++; $display("FAIL clear_state got %h want 0", {locked_a, errors_a, words_a}); end
    for (int k = 0; k < 4; k++) drive(1, 0, 2'b10, 1, 24'hFFFFFA + 24'(k));
    n_vec++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL wrap_lock got %b want 1", locked_a); end
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 2'b10, 1, 24'hFFFFFE + 24'(k));
      n_vec++; if (error_a !== 1'b0) begin n_bad++; $display("FAIL wrap_err[%0d] got %b want 0", k, error_a); end
    end
    n_vec++; if (words_a !== 16'd3 || errors_a !== 16'd0) begin n_bad++; $display("FAIL wrap_counts got w=%0d e=%0d want w=3 e=0", words_a, errors_a); end
  endtask

  task automatic test_mfsr();
    bit [31:0] s[8];
    s[0] = 32'h1;
    for (int k = 1; k < 8; k++) s[k] = mfsr_next(s[k-1]);
    drive(1, 0, 2'b01, 0, 24'h0);
    n_vec++; if (locked_a !== 1'b0 || words_a !== 16'd3) begin n_bad++; $display("FAIL mode_to_mfsr got l=%b w=%0d want l=0 w=3", locked_a, words_a); end
    drive(1, 1, 2'b01, 0, 24'h0);
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 2'b01, 1, (k == 5) ? (s[k][23:0] ^ 24'h1) : s[k][23:0]);
      if (k == 2) begin n_vec++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL mfsr_early got %b want 0", locked_a); end end
      if (k >= 3) begin n_vec++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL mfsr_lock[%0d] got %b want 1", k, locked_a); end end
      if (k >= 4) begin n_vec++; if (error_a !== (k == 5)) begin n_bad++; $display("FAIL mfsr_err[%0d] got %b want %b", k, error_a, k == 5); end end
    end
    n_vec++; if (words_a !== 16'd4 || errors_a !== 16'd1) begin n_bad++; $display("FAIL mfsr_counts got w=%0d e=%0d want w=4 e=1", words_a, errors_a); end
  endtask

  task automatic test_const_loss();
    drive(1, 0, 2'b00, 0, 24'h0);
    drive(1, 1, 2'b00, 0, 24'h0);
    for (int k = 0; k < 4; k++) drive(1, 0, 2'b00, 1, 24'h0);
    n_vec++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL const_lock got %b want 1", locked_a); end
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 2'b00, 1, 24'h1);
      n_vec++; if (errors_a !== 16'(k + 1)) begin n_bad++; $display("FAIL const_errors[%0d] got %0d want %0d", k, errors_a, k + 1); end
      n_vec++; if (locked_a !== (k < 3)) begin n_bad++; $display("FAIL const_loss[%0d] got %b want %b", k, locked_a, k < 3); end
    end
    n_vec++; if (locked_b !== 1'b1 || errors_b !== 4'd4) begin n_bad++; $display("FAIL longloss_hold got l=%b e=%0d want l=1 e=4", locked_b, errors_b); end
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 2'b00, 1, 24'h0);
      n_vec++; if (locked_a !== (k == 3)) begin n_bad++; $display("FAIL const_relock[%0d] got %b want %b", k, locked_a, k == 3); end
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 20; k++) drive(1, 0, 2'b00, 1, 24'h1);
    n_vec++; if (errors_b !== 4'hF || words_b !== 4'hF) begin n_bad++; $display("FAIL sat_counts got e=%0d w=%0d want 15 15", errors_b, words_b); end
    n_vec++; if (locked_b !== 1'b1) begin n_bad++; $display("FAIL sat_locked got %b want 1", locked_b); end
    n_vec++; if (errors_a !== 16'd8) begin n_bad++; $display("FAIL sat_errors_a got %0d want 8", errors_a); end
    drive(1, 1, 2'b00, 1, 24'h1);
    n_vec++; if (errors_b !== 4'h0 || error_b !== 1'b0 || locked_b !== 1'b0) begin n_bad++; $display("FAIL clear_vs_word got e=%0d p=%b l=%b want 0 0 0", errors_b, error_b, locked_b); end
  endtask

  task automatic test_mode_change();
    drive(1, 0, 2'b10, 0, 24'h0);
    for (int k = 0; k < 4; k++) drive(1, 0, 2'b10, 1, 24'd100 + 24'(k));
    drive(1, 0, 2'b10, 1, 24'd200);
    n_vec++; if (locked_a !== 1'b1 || errors_a !== 16'd1 || words_a !== 16'd1) begin n_bad++; $display("FAIL pre_mode got l=%b e=%0d w=%0d want 1 1 1", locked_a, errors_a, words_a); end
    drive(1, 0, 2'b01, 1, 24'd201);
    n_vec++; if (locked_a !== 1'b0 || errors_a !== 16'd1 || words_a !== 16'd1 || error_a !== 1'b0) begin n_bad++; $display("FAIL mode_change got l=%b e=%0d w=%0d p=%b want 0 1 1 0", locked_a, errors_a, words_a, error_a); end
  endtask

  task automatic test_async_reset();
    bit [31:0] s;
    s = 32'h1;
    for (int k = 0; k < 5; k++) begin drive(1, 0, 2'b01, 1, s[23:0]); s = mfsr_next(s); end
    n_vec++; if (locked_a !== 1'b1 || words_a !== 16'd2) begin n_bad++; $display("FAIL pre_reset got l=%b w=%0d want 1 2", locked_a, words_a); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if ({locked_a, error_a, errors_a, words_a} !== 34'h0) begin n_bad++; $display("FAIL async_reset got %h want 0", {locked_a, error_a, errors_a, words_a}); end
    n_vec++; if ({locked_b, error_b, errors_b, words_b} !== 10'h0) begin n_bad++; $display("FAIL async_reset_b got %h want 0", {locked_b, error_b, errors_b, words_b}); end
    model_reset();
    drive(1, 0, 2'b01, 0, 24'h0);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    bit [1:0] md;
    md = 2'b10;
    for (int n = 0; n < 3000; n++) begin
      bit en, clr, vld;
      bit [23:0] d;
      if ($urandom_range(99) < 3) md = 2'($urandom_range(3));
      en  = ($urandom_range(99) >= 2);
      clr = ($urandom_range(99) < 2);
      vld = ($urandom_range(99) < 80);
      d   = ($urandom_range(99) < 85) ? model_expect(0, md) : 24'($urandom);
      drive(en, clr, md, vld, d);
      n_vec++; if (locked_a !== (m_st[0] == 2) || error_a !== m_err[0]) begin n_bad++; $display("FAIL rnd_flags_a @%0d got l=%b p=%b want l=%b p=%b", n, locked_a, error_a, m_st[0] == 2, m_err[0]); end
      n_vec++; if (errors_a !== 16'(m_errs[0]) || words_a !== 16'(m_words[0])) begin n_bad++; $display("FAIL rnd_counts_a @%0d got e=%0d w=%0d want e=%0d w=%0d", n, errors_a, words_a, m_errs[0], m_words[0]); end
      n_vec++; if (locked_b !== (m_st[1] == 2) || error_b !== m_err[1]) begin n_bad++; $display("FAIL rnd_flags_b @%0d got l=%b p=%b want l=%b p=%b", n, locked_b, error_b, m_st[1] == 2, m_err[1]); end
      n_vec++; if (errors_b !== 4'(m_errs[1]) || words_b !== 4'(m_words[1])) begin n_bad++; $display("FAIL rnd_counts_b @%0d got e=%0d w=%0d want e=%0d w=%0d", n, errors_b, words_b, m_errs[1], m_words[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_counter_lock();
    test_counter_wrap();
    test_mfsr();
    test_const_loss();
    test_saturate();
    test_mode_change();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
